// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline stage register with valid/ready handshake, synchronous flush,
// control squash on bubbles and a saturating back-pressure counter.
// Optional feature macro: EXE_MEM_STAGE_SKID_EN adds a second (skid) entry and a
// registered in_ready; when undefined the stage holds a single entry and in_ready
// is combinational.

module exe_mem_stage #(
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]            in_reg,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic [REG_W-1:0]            out_reg,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int unsigned DW = NUM_LANES * DATA_W;
    localparam logic [CNT_W-1:0] CntMax = '1;

`ifdef EXE_MEM_STAGE_SKID_EN
    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;
`else
    typedef enum logic [0:0] {StEmpty, StFull} state_e;
`endif

    state_e              state_q;
    logic                valid_q;
    logic [CTRL_W-1:0]   main_ctrl_q;
    logic [DW-1:0]       main_data_q;
    logic [REG_W-1:0]    main_reg_q;
    logic [CNT_W-1:0]    stall_cnt_q;

`ifdef EXE_MEM_STAGE_SKID_EN
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic [DW-1:0]       skid_data_q;
    logic [REG_W-1:0]    skid_reg_q;
    logic                in_ready_q;
`endif

    logic accept;
    logic out_xfer;

`ifdef EXE_MEM_STAGE_SKID_EN
    assign in_ready = in_ready_q;
`else
    assign in_ready = !valid_q || out_ready;
`endif

    assign accept    = in_valid && in_ready;
    assign out_xfer  = valid_q && out_ready;

    assign out_valid = valid_q;
    // A bubble must never leak regwrite/memwrite downstream.
    assign out_ctrl  = main_ctrl_q & {CTRL_W{valid_q}};
    assign out_data  = main_data_q;
    assign out_reg   = main_reg_q;
    assign stall_cnt = stall_cnt_q;

    // Stage FSM, payload registers and stall counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StEmpty;
            valid_q     <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_reg_q  <= '0;
            stall_cnt_q <= '0;
`ifdef EXE_MEM_STAGE_SKID_EN
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_reg_q  <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            // Counter sees the current out_valid, so flush does not disturb it.
            if (valid_q && !out_ready && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end

            if (flush) begin
                state_q <= StEmpty;
                valid_q <= 1'b0;
`ifdef EXE_MEM_STAGE_SKID_EN
                in_ready_q <= 1'b1;
`endif
            end else begin
                case (state_q)
                    StEmpty: begin
                        if (accept) begin
                            main_ctrl_q <= in_ctrl;
                            main_data_q <= in_data;
                            main_reg_q  <= in_reg;
                            state_q     <= StFull;
                            valid_q     <= 1'b1;
                        end
                    end
                    StFull: begin
                        if (accept && out_xfer) begin
                            main_ctrl_q <= in_ctrl;
                            main_data_q <= in_data;
                            main_reg_q  <= in_reg;
`ifdef EXE_MEM_STAGE_SKID_EN
                        end else if (accept) begin
                            // Downstream stalled: park the new word behind main.
                            skid_ctrl_q <= in_ctrl;
                            skid_data_q <= in_data;
                            skid_reg_q  <= in_reg;
                            state_q     <= StSkid;
                            in_ready_q  <= 1'b0;
`endif
                        end else if (out_xfer) begin
                            state_q <= StEmpty;
                            valid_q <= 1'b0;
                        end
                    end
`ifdef EXE_MEM_STAGE_SKID_EN
                    StSkid: begin
                        if (out_xfer) begin
                            main_ctrl_q <= skid_ctrl_q;
                            main_data_q <= skid_data_q;
                            main_reg_q  <= skid_reg_q;
                            state_q     <= StFull;
                            in_ready_q  <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_q <= StEmpty;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed self-checking bench for exe_mem_stage (CNT_W=4 to reach saturation).
// Back-pressure and async-reset sections adapt to EXE_MEM_STAGE_SKID_EN.

module tb_exe_mem_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [63:0] in_data;
    logic [4:0]  in_reg;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctrl;
    logic [63:0] out_data;
    logic [4:0]  out_reg;
    logic [3:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    exe_mem_stage #(
        .CTRL_W   (4),
        .DATA_W   (32),
        .NUM_LANES(2),
        .REG_W    (5),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .in_reg   (in_reg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .out_reg  (out_reg),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_ctrl   = 4'b0;
        in_data   = 64'h0;
        in_reg    = 5'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] lane0, input logic [4:0] r);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = {lane0 ^ 32'hFFFF_0000, lane0};
        in_reg   = r;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #2;
        check_eq("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check_eq("rst_out_ctrl", {60'b0, out_ctrl}, 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_reg", {59'b0, out_reg}, 64'd0);
        check_eq("rst_stall_cnt", {60'b0, stall_cnt}, 64'd0);
        check_eq("rst_in_ready", {63'b0, in_ready}, 64'd1);
        #10;
        reset_n = 1'b1;

        // Streaming at full rate.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            send(4'b1001, 32'h10 + i, 5'(i));
            tick();
            check_eq($sformatf("stream_valid_%0d", i), {63'b0, out_valid}, 64'd1);
            check_eq($sformatf("stream_lane0_%0d", i), {32'b0, out_data[31:0]}, 64'h10 + i);
            check_eq($sformatf("stream_lane1_%0d", i), {32'b0, out_data[63:32]},
                     {32'b0, (32'h10 + i) ^ 32'hFFFF_0000});
            check_eq($sformatf("stream_reg_%0d", i), {59'b0, out_reg}, 64'(i));
            check_eq($sformatf("stream_ctrl_%0d", i), {60'b0, out_ctrl}, 64'h9);
        end
        in_valid = 1'b0;
        tick();
        check_eq("stream_drain_valid", {63'b0, out_valid}, 64'd0);
        check_eq("stream_drain_ctrl", {60'b0, out_ctrl}, 64'd0);
        check_eq("stream_hold_lane0", {32'b0, out_data[31:0]}, 64'h17);
        check_eq("stream_stall_cnt", {60'b0, stall_cnt}, 64'd0);

        // Back-pressure.
        apply_reset();
        out_ready = 1'b0;
        send(4'b1000, 32'hA1, 5'd1);
        tick();
        check_eq("bp_a1_valid", {63'b0, out_valid}, 64'd1);
        check_eq("bp_a1_data", {32'b0, out_data[31:0]}, 64'hA1);
`ifdef EXE_MEM_STAGE_SKID_EN
        check_eq("bp_ready_full", {63'b0, in_ready}, 64'd1);
        send(4'b1000, 32'hA2, 5'd2);
        tick();
        check_eq("bp_ready_skid", {63'b0, in_ready}, 64'd0);
        check_eq("bp_hold_a1", {32'b0, out_data[31:0]}, 64'hA1);
        send(4'b1000, 32'hA3, 5'd3);
        tick();
        check_eq("bp_still_a1", {32'b0, out_data[31:0]}, 64'hA1);
        check_eq("bp_ready_skid2", {63'b0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        check_eq("bp_out_a2", {32'b0, out_data[31:0]}, 64'hA2);
        check_eq("bp_reg_a2", {59'b0, out_reg}, 64'd2);
        check_eq("bp_ready_back", {63'b0, in_ready}, 64'd1);
        tick();
        check_eq("bp_out_a3", {32'b0, out_data[31:0]}, 64'hA3);
        check_eq("bp_valid_a3", {63'b0, out_valid}, 64'd1);
        in_valid = 1'b0;
        tick();
        check_eq("bp_empty", {63'b0, out_valid}, 64'd0);
        check_eq("bp_stall_cnt", {60'b0, stall_cnt}, 64'd2);
`else
        check_eq("bp_ready_blocked", {63'b0, in_ready}, 64'd0);
        send(4'b1000, 32'hA2, 5'd2);
        tick();
        check_eq("bp_hold_a1", {32'b0, out_data[31:0]}, 64'hA1);
        check_eq("bp_ready_blocked2", {63'b0, in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_ready_comb", {63'b0, in_ready}, 64'd1);
        tick();
        check_eq("bp_out_a2", {32'b0, out_data[31:0]}, 64'hA2);
        in_valid = 1'b0;
        tick();
        check_eq("bp_empty", {63'b0, out_valid}, 64'd0);
        check_eq("bp_stall_cnt", {60'b0, stall_cnt}, 64'd1);
`endif

        // Flush overriding a same-cycle accept.
        apply_reset();
        send(4'b1111, 32'h55, 5'd5);
        tick();
        check_eq("fl_full_ctrl", {60'b0, out_ctrl}, 64'hF);
        send(4'b1111, 32'h66, 5'd9);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_valid", {63'b0, out_valid}, 64'd0);
        check_eq("fl_ctrl", {60'b0, out_ctrl}, 64'd0);
        check_eq("fl_reg_kept", {59'b0, out_reg}, 64'd5);
        check_eq("fl_data_kept", {32'b0, out_data[31:0]}, 64'h55);
        tick();
        check_eq("fl_no_resurrect", {63'b0, out_valid}, 64'd0);

        // Bubble squash.
        apply_reset();
        in_valid = 1'b0;
        in_ctrl  = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("bubble_ctrl_%0d", i), {60'b0, out_ctrl}, 64'd0);
        end

        // Stall counter saturation.
        apply_reset();
        send(4'b0001, 32'h77, 5'd7);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check_eq($sformatf("sat_cnt_%0d", k), {60'b0, stall_cnt}, (k > 15) ? 64'd15 : 64'(k));
        end
        out_ready = 1'b1;
        tick();
        check_eq("sat_hold", {60'b0, stall_cnt}, 64'd15);

        // Asynchronous reset between edges with stage loaded and stalled.
        apply_reset();
        out_ready = 1'b0;
        send(4'b1100, 32'hC1, 5'd11);
        tick();
        send(4'b1100, 32'hC2, 5'd12);
        tick();
        in_valid = 1'b0;
        check_eq("ar_pre_valid", {63'b0, out_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_valid", {63'b0, out_valid}, 64'd0);
        check_eq("ar_ctrl", {60'b0, out_ctrl}, 64'd0);
        check_eq("ar_data", out_data, 64'd0);
        check_eq("ar_reg", {59'b0, out_reg}, 64'd0);
        check_eq("ar_stall", {60'b0, stall_cnt}, 64'd0);
        check_eq("ar_in_ready", {63'b0, in_ready}, 64'd1);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(4'b0011, 32'hB0, 5'd3);
        tick();
        in_valid = 1'b0;
        check_eq("ar_next_valid", {63'b0, out_valid}, 64'd1);
        check_eq("ar_next_data", {32'b0, out_data[31:0]}, 64'hB0);
        check_eq("ar_next_ctrl", {60'b0, out_ctrl}, 64'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
